// File: rtl/dpram_defs.sv
// Shared definitions for the dual-port RAM self-test sequencer.
// Holds the FSM state encodings and the default RAM geometry.
package dpram_defs;
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/edge_detector.sv
// Two-flop rising-edge detector on a level input.
// The output is high for one cycle after the first edge that samples din = 1.
module edge_detector (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic dout
);
  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign dout = s1 & ~s2;
endmodule

// File: rtl/dpram_bist_ctrl.sv
// Self-test sequencer for the dual-port RAM: writes a seeded ramp through port A,
// reads it back through port B, and reports pass/fail, error count and first bad address.
module dpram_bist_ctrl
  import dpram_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] base,
                                                input logic [ADDR_W-1:0] addr);
    return base + DATA_W'(addr);
  endfunction

  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   cnt, cnt_nx;
  logic [DATA_W-1:0]   seed_q, seed_nx;
  logic                start_rise;
  logic                launch;
  logic                mismatch;
  logic [ADDR_W:0]     err_cnt_nx;
  logic [ADDR_W-1:0]   first_err_nx;

  logic                vld_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [DATA_W-1:0]   exp_p1;

  edge_detector u_start_edge (
    .clk   (clk),
    .n_rst (n_rst),
    .din   (start),
    .dout  (start_rise)
  );

  assign launch = (state == ST_IDLE) && start_rise;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      seed_q <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      seed_q <= seed_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    seed_nx  = seed_q;
    case (state)
      ST_IDLE: begin
        if (start_rise) begin
          state_nx = ST_WRITE;
          cnt_nx   = '0;
          seed_nx  = seed;
        end
      end
      ST_WRITE: begin
        if (&cnt) begin
          state_nx = ST_READ;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ADDR_W'(1);
        end
      end
      ST_READ: begin
        if (&cnt) begin
          state_nx = ST_DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ADDR_W'(1);
        end
      end
      ST_DRAIN: state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Compare stage: rd_data answers the read issued in the previous cycle
  always_comb begin
    mismatch     = vld_p1 && (rd_data != exp_p1);
    err_cnt_nx   = err_cnt;
    first_err_nx = first_err_addr;
    if (launch) begin
      err_cnt_nx   = '0;
      first_err_nx = '0;
    end else if (mismatch) begin
      if (err_cnt == '0) first_err_nx = addr_p1;
      err_cnt_nx = sat_inc(err_cnt);
    end
  end

  // Port and status registers, driven from next-state so they line up with the state
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      vld_p1         <= 1'b0;
    end else begin
      wr_en          <= (state_nx == ST_WRITE);
      wr_addr        <= (state_nx == ST_WRITE) ? cnt_nx : '0;
      wr_data        <= (state_nx == ST_WRITE) ? pattern(seed_nx, cnt_nx) : '0;
      rd_en          <= (state_nx == ST_READ);
      rd_addr        <= (state_nx == ST_READ) ? cnt_nx : '0;
      busy           <= (state_nx != ST_IDLE);
      done           <= (state_nx == ST_DONE);
      err_cnt        <= err_cnt_nx;
      first_err_addr <= first_err_nx;
      vld_p1         <= rd_en;
      if (launch) pass <= 1'b0;
      else if (state_nx == ST_DONE) pass <= (err_cnt_nx == '0);
    end
  end

  // Expected-data pipeline, qualified by vld_p1
  always_ff @(posedge clk) begin
    addr_p1 <= rd_addr;
    exp_p1  <= pattern(seed_q, rd_addr);
  end

endmodule
